// File: rtl/ula_nbits_seq_if.sv
// Operand/opcode request and result/flag bus for the sequential ULA.
interface ula_nbits_seq_if #(parameter int W = 4);
  logic [W-1:0]   A_in;
  logic [W-1:0]   B_in;
  logic           Cin;
  logic [2:0]     OP_sel;
  logic           start;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic           LED_Cout;
  logic           LED_OV;
  logic           LED_Z;
  logic           LED_ERR;

  modport master (
    output A_in, B_in, Cin, OP_sel, start,
    input  busy, done, result, LED_Cout, LED_OV, LED_Z, LED_ERR
  );

  modport slave (
    input  A_in, B_in, Cin, OP_sel, start,
    output busy, done, result, LED_Cout, LED_OV, LED_Z, LED_ERR
  );
endinterface

// File: rtl/ula_nbits_seq.sv
// Clocked W-bit ALU: single-cycle ADD/SUB/logic ops, W-cycle shift-add MUL
// and restoring DIV, with registered result and LED flags.
module ula_nbits_seq #(
  parameter int W = 4
) (
  input logic             CLK,
  input logic             RST_n,
  ula_nbits_seq_if.slave  bus
);

  localparam int CW = $clog2(W) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;

  logic [1:0]     state;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] p;

  logic [W:0]     add_full;
  logic [W:0]     sub_full;
  logic [2*W-1:0] fast_res;
  logic           fast_cout;
  logic           fast_ov;
  logic           fast_err;
  logic           multi;

  logic [W:0]     mul_sum;
  logic [W:0]     div_trial;
  logic [2*W-1:0] p_next;

  always_comb begin
    add_full  = {1'b0, bus.A_in} + {1'b0, bus.B_in} + {{W{1'b0}}, bus.Cin};
    sub_full  = {1'b0, bus.A_in} - {1'b0, bus.B_in} - {{W{1'b0}}, bus.Cin};
    fast_res  = '0;
    fast_cout = 1'b0;
    fast_ov   = 1'b0;
    fast_err  = 1'b0;
    case (bus.OP_sel)
      OP_ADD: begin
        fast_res  = {{W{1'b0}}, add_full[W-1:0]};
        fast_cout = add_full[W];
        fast_ov   = (bus.A_in[W-1] == bus.B_in[W-1]) && (add_full[W-1] != bus.A_in[W-1]);
      end
      OP_SUB: begin
        fast_res  = {{W{1'b0}}, sub_full[W-1:0]};
        fast_cout = sub_full[W];
        fast_ov   = (bus.A_in[W-1] != bus.B_in[W-1]) && (sub_full[W-1] != bus.A_in[W-1]);
      end
      OP_AND:  fast_res = {{W{1'b0}}, bus.A_in & bus.B_in};
      OP_OR:   fast_res = {{W{1'b0}}, bus.A_in | bus.B_in};
      OP_XOR:  fast_res = {{W{1'b0}}, bus.A_in ^ bus.B_in};
      default: fast_err = 1'b1;
    endcase
    multi = (bus.OP_sel == OP_MUL) || ((bus.OP_sel == OP_DIV) && (|bus.B_in));
  end

  // p holds {hi, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    mul_sum   = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, a_q} : {(W+1){1'b0}});
    div_trial = {p[2*W-1:W], p[W-1]} - {1'b0, b_q};
    if (state == S_MUL)
      p_next = {mul_sum, p[W-1:1]};
    else if (div_trial[W])
      p_next = {p[2*W-2:0], 1'b0};
    else
      p_next = {div_trial[W-1:0], p[W-2:0], 1'b1};
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state        <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      cnt          <= '0;
      p            <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.result   <= '0;
      bus.LED_Cout <= 1'b0;
      bus.LED_OV   <= 1'b0;
      bus.LED_Z    <= 1'b1;
      bus.LED_ERR  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (multi) begin
              a_q      <= bus.A_in;
              b_q      <= bus.B_in;
              cnt      <= '0;
              bus.busy <= 1'b1;
              if (bus.OP_sel == OP_MUL) begin
                state <= S_MUL;
                p     <= {{W{1'b0}}, bus.B_in};
              end else begin
                state <= S_DIV;
                p     <= {{W{1'b0}}, bus.A_in};
              end
            end else begin
              bus.result   <= fast_res;
              bus.LED_Cout <= fast_cout;
              bus.LED_OV   <= fast_ov;
              bus.LED_Z    <= (fast_res == '0);
              bus.LED_ERR  <= fast_err;
              bus.done     <= 1'b1;
            end
          end
        end
        S_MUL, S_DIV: begin
          p   <= p_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            bus.result   <= p_next;
            bus.LED_Cout <= 1'b0;
            bus.LED_OV   <= 1'b0;
            bus.LED_Z    <= (p_next == '0);
            bus.LED_ERR  <= 1'b0;
            bus.done     <= 1'b1;
            bus.busy     <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_nbits_seq.sv
// Randomized and directed bench for ula_nbits_seq against an arithmetic
// reference model; also exercises a W=8 instance.
module tb_ula_nbits_seq;

  localparam int W  = 4;
  localparam int W8 = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ula_nbits_seq_if #(.W(W))  bus ();
  ula_nbits_seq_if #(.W(W8)) bus8 ();

  ula_nbits_seq #(.W(W))  dut  (.CLK(clk), .RST_n(rst_n), .bus(bus.slave));
  ula_nbits_seq #(.W(W8)) dut8 (.CLK(clk), .RST_n(rst_n), .bus(bus8.slave));

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Plain integer arithmetic; signed overflow judged by range of the true sum
  function automatic void refModel(input int a, input int b, input int cin, input int op,
                                   output logic [31:0] res, output logic cout,
                                   output logic ov, output logic err);
    int full = 1 << W;
    int half = 1 << (W - 1);
    int sa = (a >= half) ? a - full : a;
    int sb = (b >= half) ? b - full : b;
    int t;
    res = '0; cout = 1'b0; ov = 1'b0; err = 1'b0;
    case (op)
      0: begin
        t = a + b + cin;
        res = 32'(t % full);
        cout = (t >= full);
        ov = ((sa + sb + cin) > half - 1) || ((sa + sb + cin) < -half);
      end
      1: begin
        t = a - b - cin;
        res = 32'((t + full) % full);
        cout = (a < b + cin);
        ov = ((sa - sb - cin) > half - 1) || ((sa - sb - cin) < -half);
      end
      2: res = 32'(a & b);
      3: res = 32'(a | b);
      4: res = 32'(a ^ b);
      5: res = 32'(a * b);
      6: begin
        if (b == 0) err = 1'b1;
        else res = 32'((a % b) * full + a / b);
      end
      default: err = 1'b1;
    endcase
  endfunction

  task automatic applyStimulus(input int a, input int b, input int cin, input int op, input bit b2b);
    logic [31:0] eres;
    logic ec, eo, ee;
    int cycles, busyc;
    bit multi;
    if (!b2b) begin
      @(negedge clk);
      checkOutput("done_idle", 32'(bus.done), 32'd0);
    end
    refModel(a, b, cin, op, eres, ec, eo, ee);
    multi = (op == 5) || (op == 6 && b != 0);
    bus.A_in   = a[W-1:0];
    bus.B_in   = b[W-1:0];
    bus.Cin    = cin[0];
    bus.OP_sel = op[2:0];
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.A_in   = W'($urandom);
    bus.B_in   = W'($urandom);
    bus.Cin    = 1'($urandom);
    bus.OP_sel = 3'($urandom);
    cycles = 1;
    busyc  = 0;
    while (!bus.done && cycles < 40) begin
      if (bus.busy) busyc++;
      @(negedge clk);
      cycles++;
    end
    checkOutput($sformatf("op%0d_latency", op), 32'(cycles), multi ? 32'(W + 1) : 32'd1);
    checkOutput($sformatf("op%0d_busy", op), 32'(busyc), multi ? 32'(W) : 32'd0);
    checkOutput($sformatf("op%0d %0d,%0d result", op, a, b), 32'(bus.result), eres);
    checkOutput($sformatf("op%0d cout", op), 32'(bus.LED_Cout), 32'(ec));
    checkOutput($sformatf("op%0d ov", op), 32'(bus.LED_OV), 32'(eo));
    checkOutput($sformatf("op%0d z", op), 32'(bus.LED_Z), 32'(eres == 0));
    checkOutput($sformatf("op%0d err", op), 32'(bus.LED_ERR), 32'(ee));
  endtask

  initial begin
    int dcount, dfirst, cycles, busyc;
    bus.A_in = '0;  bus.B_in = '0;  bus.Cin = 1'b0;  bus.OP_sel = '0;  bus.start = 1'b0;
    bus8.A_in = '0; bus8.B_in = '0; bus8.Cin = 1'b0; bus8.OP_sel = '0; bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_result", 32'(bus.result), 32'd0);
    checkOutput("rst_z", 32'(bus.LED_Z), 32'd1);
    checkOutput("rst_err", 32'(bus.LED_ERR), 32'd0);
    checkOutput("rst_cout", 32'(bus.LED_Cout), 32'd0);
    rst_n = 1'b1;

    applyStimulus(7, 9, 0, 0, 1'b0);
    applyStimulus(7, 1, 0, 0, 1'b0);
    applyStimulus(3, 5, 0, 1, 1'b0);
    applyStimulus(8, 1, 0, 1, 1'b0);
    applyStimulus(15, 15, 0, 5, 1'b0);
    applyStimulus(13, 4, 0, 6, 1'b0);
    applyStimulus(5, 0, 0, 6, 1'b0);
    applyStimulus(1, 1, 0, 0, 1'b0);
    applyStimulus(2, 3, 0, 7, 1'b0);
    applyStimulus(6, 3, 0, 5, 1'b0);
    applyStimulus(9, 2, 1, 1, 1'b1);

    // A start issued mid-MUL must be dropped, leaving exactly one done pulse
    @(negedge clk);
    bus.A_in = 4'd15; bus.B_in = 4'd15; bus.OP_sel = 3'b101; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    dcount = 0;
    dfirst = 0;
    for (int i = 1; i <= 3 * W; i++) begin
      if (bus.done) begin
        dcount++;
        if (dfirst == 0) begin
          dfirst = i;
          checkOutput("ignored_start_result", 32'(bus.result), 32'(15 * 15));
        end
      end
      bus.start = (i == 2);
      if (i == 2) begin
        bus.A_in = 4'd1; bus.B_in = 4'd1; bus.OP_sel = 3'b000;
      end
      @(negedge clk);
    end
    checkOutput("ignored_start_pulses", 32'(dcount), 32'd1);
    checkOutput("ignored_start_latency", 32'(dfirst), 32'(W + 1));

    // Reset during the second busy cycle aborts MUL silently
    bus.A_in = 4'd15; bus.B_in = 4'd15; bus.OP_sel = 3'b101; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_result", 32'(bus.result), 32'd0);
    checkOutput("abort_z", 32'(bus.LED_Z), 32'd1);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 3 * W; i++) begin
      if (bus.done) dcount++;
      @(negedge clk);
    end
    checkOutput("abort_no_done", 32'(dcount), 32'd0);

    bus8.A_in = 8'd200; bus8.B_in = 8'd200; bus8.OP_sel = 3'b101; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    cycles = 1;
    busyc  = 0;
    while (!bus8.done && cycles < 40) begin
      if (bus8.busy) busyc++;
      @(negedge clk);
      cycles++;
    end
    checkOutput("w8_mul_busy", 32'(busyc), 32'(W8));
    checkOutput("w8_mul_result", 32'(bus8.result), 32'(200 * 200));

    for (int i = 0; i < 40; i++) begin
      int op, a, b, cin;
      op  = int'($urandom_range(0, 7));
      a   = int'($urandom_range(0, (1 << W) - 1));
      b   = int'($urandom_range(0, (1 << W) - 1));
      cin = int'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) b = 0;
      applyStimulus(a, b, cin, op, (i > 0) && ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
